nand_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one NAND bus among up to eight chip-target requesters. The bus is the shared DQ/DQS/CLE/ALE/WRN group, and each target has its own active-low chip enable. The arbiter sits between the per-target command sequencers and the bus PHY. It grants exclusive tenure to one target at a time, drives that target's CEN low, and inserts a bus turnaround gap between tenures. It also reclaims the bus from an owner that holds it past a configurable limit.

---
 rtl/nand_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_nand_bus_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/nand_bus_arbiter.sv
// Round-robin owner arbitration for a shared NAND DQ/CLE/ALE bus with per-target CE#.
// Grants one tenure at a time, enforces a turnaround gap and reclaims the bus after MAX_HOLD cycles.
module nand_bus_arbiter #(
    parameter int NREQ     = 8,
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 4096,
    parameter int HW       = 13
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] rel,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] cen,
    output logic [2:0]      owner,
    output logic            bus_busy,
    output logic            timeout,
    output logic [2:0]      timeout_id
);

    localparam int TW = $clog2(TURN_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t          state_r, state_nx_s;
    logic [NREQ-1:0] gnt_r, gnt_nx_s, cen_r;
    logic [2:0]      owner_r, owner_nx_s;
    logic [2:0]      ptr_r, ptr_nx_s;
    logic [HW-1:0]   hold_r, hold_nx_s;
    logic [TW-1:0]   turn_r, turn_nx_s;
    logic            busy_r;
    logic            timeout_r, timeout_nx_s;
    logic [2:0]      tid_r, tid_nx_s;
    logic [3:0]      pick_s;
    logic            own_rel_s, own_req_s, hold_hit_s;

    // First requester at or after p, wrapping modulo NREQ; result is {found, index}.
    function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = 3'((int'(p) + i) % NREQ);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s     = rr_pick(req, ptr_r);
    assign own_rel_s  = rel[owner_r];
    assign own_req_s  = req[owner_r];
    assign hold_hit_s = (MAX_HOLD != 0) && (hold_r == HW'(MAX_HOLD));

    // Next-state and next-output logic for the tenure FSM.
    always_comb begin
        state_nx_s   = state_r;
        gnt_nx_s     = gnt_r;
        owner_nx_s   = owner_r;
        ptr_nx_s     = ptr_r;
        hold_nx_s    = hold_r;
        turn_nx_s    = turn_r;
        timeout_nx_s = 1'b0;
        tid_nx_s     = tid_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[3]) begin
                    gnt_nx_s   = {{(NREQ-1){1'b0}}, 1'b1} << pick_s[2:0];
                    owner_nx_s = pick_s[2:0];
                    hold_nx_s  = HW'(1);
                    state_nx_s = ST_OWN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (own_rel_s || !own_req_s || hold_hit_s) begin
                    gnt_nx_s   = {NREQ{1'b0}};
                    ptr_nx_s   = 3'((int'(owner_r) + 1) % NREQ);
                    turn_nx_s  = TW'(TURN_CYC - 1);
                    state_nx_s = ST_TURN;
                    // A voluntary release or withdrawal on the limit edge is not a forced end.
                    if (hold_hit_s && !own_rel_s && own_req_s) begin
                        timeout_nx_s = 1'b1;
                        tid_nx_s     = owner_r;
                    end else begin
                        timeout_nx_s = 1'b0;
                    end
                end else if (hold_r != {HW{1'b1}}) begin
                    hold_nx_s = hold_r + HW'(1);
                end else begin
                    hold_nx_s = hold_r;
                end
            end
            ST_TURN: begin
                gnt_nx_s = {NREQ{1'b0}};
                if (turn_r == TW'(0)) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    turn_nx_s = turn_r - TW'(1);
                end
            end
            default: begin
                gnt_nx_s   = {NREQ{1'b0}};
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops every CE at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            gnt_r     <= {NREQ{1'b0}};
            cen_r     <= {NREQ{1'b1}};
            owner_r   <= 3'd0;
            ptr_r     <= 3'd0;
            hold_r    <= {HW{1'b0}};
            turn_r    <= {TW{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            tid_r     <= 3'd0;
        end else begin
            state_r   <= state_nx_s;
            gnt_r     <= gnt_nx_s;
            cen_r     <= ~gnt_nx_s;
            owner_r   <= owner_nx_s;
            ptr_r     <= ptr_nx_s;
            hold_r    <= hold_nx_s;
            turn_r    <= turn_nx_s;
            busy_r    <= |gnt_nx_s;
            timeout_r <= timeout_nx_s;
            tid_r     <= tid_nx_s;
        end
    end

    assign gnt        = gnt_r;
    assign cen        = cen_r;
    assign owner      = owner_r;
    assign bus_busy   = busy_r;
    assign timeout    = timeout_r;
    assign timeout_id = tid_r;

endmodule

// File: tb/tb_nand_bus_arbiter.sv
// Directed bench for nand_bus_arbiter: round-robin order, turnaround gap, timeout,
// ignored/coincident inputs, withdrawal and asynchronous reset.
module tb_nand_bus_arbiter;

    logic       CLK;
    logic       RST;
    logic [7:0] req;
    logic [7:0] rel;
    logic [7:0] gnt;
    logic [7:0] cen;
    logic [2:0] owner;
    logic       bus_busy;
    logic       timeout;
    logic [2:0] timeout_id;

    int errors = 0;
    int checks = 0;

    nand_bus_arbiter #(
        .NREQ(8), .TURN_CYC(2), .MAX_HOLD(16), .HW(5)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .rel(rel),
        .gnt(gnt), .cen(cen), .owner(owner), .bus_busy(bus_busy),
        .timeout(timeout), .timeout_id(timeout_id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] one_v;
        logic [7:0] exp_g;
        one_v = 8'h01;
        RST = 1'b1;
        req = 8'h00;
        rel = 8'h00;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h00);
        chk("rst_cen", 32'(cen), 32'hFF);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(bus_busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_tid", 32'(timeout_id), 32'd0);
        RST = 1'b0;
        tick();
        chk("idle_gnt", 32'(gnt), 32'h00);

        // Round robin: everyone requests, each owner releases 4 cycles after grant.
        req = 8'hFF;
        tick();
        for (int n = 0; n < 9; n++) begin
            exp_g = one_v << (n % 8);
            chk("rr_gnt", 32'(gnt), 32'(exp_g));
            chk("rr_owner", 32'(owner), 32'(n % 8));
            repeat (3) tick();
            chk("rr_hold", 32'(gnt), 32'(exp_g));
            rel = exp_g;
            if (n == 8) begin
                req = 8'h00;
            end
            tick();
            rel = 8'h00;
            chk("rr_rel_cen", 32'(cen), 32'hFF);
            chk("rr_rel_busy", 32'(bus_busy), 32'd0);
            tick();
            chk("rr_gap1", 32'(cen), 32'hFF);
            tick();
            chk("rr_gap2", 32'(cen), 32'hFF);
            if (n < 8) begin
                tick();
            end
        end

        // Single request on target 3, release 10 cycles after grant.
        req = 8'h08;
        tick();
        chk("single_gnt", 32'(gnt), 32'h08);
        chk("single_cen", 32'(cen), 32'hF7);
        chk("single_owner", 32'(owner), 32'd3);
        chk("single_busy", 32'(bus_busy), 32'd1);
        repeat (9) tick();
        chk("single_hold", 32'(gnt), 32'h08);
        rel = 8'h08;
        tick();
        rel = 8'h00;
        chk("single_rel0", 32'(cen), 32'hFF);
        tick();
        chk("single_rel1", 32'(cen), 32'hFF);
        tick();
        chk("single_rel2", 32'(cen), 32'hFF);
        tick();
        chk("single_regrant", 32'(gnt), 32'h08);
        req = 8'h00;
        tick();
        chk("single_drop", 32'(gnt), 32'h00);
        tick();
        tick();

        // Timeout on target 5 with target 2 also pending.
        req = 8'h20;
        tick();
        chk("to_gnt", 32'(gnt), 32'h20);
        req = 8'h24;
        repeat (15) tick();
        chk("to_last_cycle", 32'(gnt), 32'h20);
        chk("to_no_early", 32'(timeout), 32'd0);
        tick();
        chk("to_gnt_low", 32'(gnt), 32'h00);
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_id", 32'(timeout_id), 32'd5);
        tick();
        chk("to_pulse_end", 32'(timeout), 32'd0);
        chk("to_id_hold", 32'(timeout_id), 32'd5);
        tick();
        chk("to_gap", 32'(gnt), 32'h00);
        tick();
        chk("to_next_gnt", 32'(gnt), 32'h04);
        chk("to_next_owner", 32'(owner), 32'd2);

        // Non-owner release is ignored; owner release coincides with the hold limit.
        tick();
        tick();
        rel = 8'h40;
        tick();
        rel = 8'h00;
        chk("rel_nonowner", 32'(gnt), 32'h04);
        repeat (12) tick();
        chk("coin_before", 32'(gnt), 32'h04);
        rel = 8'h04;
        req = 8'h10;
        tick();
        rel = 8'h00;
        chk("coin_gnt", 32'(gnt), 32'h00);
        chk("coin_no_to", 32'(timeout), 32'd0);
        chk("coin_tid", 32'(timeout_id), 32'd5);
        tick();
        chk("coin_turn1", 32'(gnt), 32'h00);
        tick();
        chk("coin_turn2", 32'(gnt), 32'h00);
        tick();
        chk("coin_next_gnt", 32'(gnt), 32'h10);
        chk("coin_next_owner", 32'(owner), 32'd4);

        // Owner 4 withdraws its request without a release.
        tick();
        req = 8'h00;
        tick();
        chk("wd_gnt", 32'(gnt), 32'h00);
        chk("wd_cen", 32'(cen), 32'hFF);
        chk("wd_no_to", 32'(timeout), 32'd0);
        req = 8'h10;
        tick();
        chk("wd_turn1", 32'(gnt), 32'h00);
        tick();
        chk("wd_turn2", 32'(gnt), 32'h00);
        tick();
        chk("wd_regrant", 32'(gnt), 32'h10);

        // Asynchronous reset between edges mid-tenure.
        #3;
        RST = 1'b1;
        #1;
        chk("arst_cen", 32'(cen), 32'hFF);
        chk("arst_gnt", 32'(gnt), 32'h00);
        chk("arst_owner", 32'(owner), 32'd0);
        chk("arst_busy", 32'(bus_busy), 32'd0);
        chk("arst_tid", 32'(timeout_id), 32'd0);
        tick();
        RST = 1'b0;
        req = 8'h81;
        tick();
        chk("arst_first_gnt", 32'(gnt), 32'h01);
        chk("arst_first_owner", 32'(owner), 32'd0);
        req = 8'h00;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
